// File: rtl/reg_mode_cfg_ctrl_if.sv
// Addressed config bus between a host and the mode-register configuration front-end.
// Strobes are accepted in the cycle they are presented; reads answer one cycle later.
interface reg_mode_cfg_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CFG_WIDTH  = 32
);
    logic                  cfg_write;
    logic                  cfg_read;
    logic [ADDR_WIDTH-1:0] cfg_addr;
    logic [CFG_WIDTH-1:0]  cfg_wdata;
    logic [CFG_WIDTH-1:0]  cfg_rdata;
    logic                  cfg_rvalid;

    modport master (
        output cfg_write,
        output cfg_read,
        output cfg_addr,
        output cfg_wdata,
        input  cfg_rdata,
        input  cfg_rvalid
    );

    modport slave (
        input  cfg_write,
        input  cfg_read,
        input  cfg_addr,
        input  cfg_wdata,
        output cfg_rdata,
        output cfg_rvalid
    );
endinterface

// File: rtl/reg_mode_cfg_ctrl.sv
// Config front-end for a bank of mode-selectable data registers: holds per-slot mode/const,
// issues one-hot load pulses, gates clock enables with stall and serves one-cycle readback.
module reg_mode_cfg_ctrl #(
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CFG_WIDTH  = 32
) (
    input  logic                           CLK,
    input  logic                           ASYNCRESETN,
    reg_mode_cfg_ctrl_if.slave             cfg,
    input  logic                           stall,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_value,
    output logic [NUM_REGS*2-1:0]          mode,
    output logic [NUM_REGS*DATA_WIDTH-1:0] const_,
    output logic [NUM_REGS-1:0]            clk_en,
    output logic [NUM_REGS-1:0]            config_we,
    output logic [DATA_WIDTH-1:0]          config_data
);

    logic [NUM_REGS*2-1:0]          mode_q, mode_d;
    logic [NUM_REGS*DATA_WIDTH-1:0] const_q, const_d;
    logic [NUM_REGS-1:0]            config_we_q, config_we_d;
    logic [DATA_WIDTH-1:0]          config_data_q, config_data_d;
    logic [CFG_WIDTH-1:0]           rdata_q, rdata_d;
    logic                           rvalid_q, rvalid_d;

    logic [NUM_REGS-1:0] slot_sel;
    logic                is_data;
    logic                rd_accept;
    logic                unused_wdata;

    // Slot i owns addresses 2i (CTRL) and 2i+1 (DATA); anything higher selects no slot.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slot_dec
        localparam logic [ADDR_WIDTH-2:0] SlotAddr = (ADDR_WIDTH-1)'(g);
        assign slot_sel[g] = (cfg.cfg_addr[ADDR_WIDTH-1:1] == SlotAddr);
    end

    assign is_data      = cfg.cfg_addr[0];
    assign unused_wdata = ^cfg.cfg_wdata;

    always_comb begin
        mode_d        = mode_q;
        const_d       = const_q;
        config_we_d   = '0;
        config_data_d = config_data_q;
        // A write wins a collision; the read is silently dropped.
        rd_accept     = cfg.cfg_read & ~cfg.cfg_write;
        rvalid_d      = rd_accept;
        rdata_d       = '0;

        if (cfg.cfg_write && is_data && (|slot_sel)) begin
            config_we_d   = slot_sel;
            config_data_d = cfg.cfg_wdata[DATA_WIDTH-1:0];
        end

        for (int i = 0; i < NUM_REGS; i++) begin
            if (slot_sel[i]) begin
                if (cfg.cfg_write && !is_data) begin
                    mode_d[i*2 +: 2]                   = cfg.cfg_wdata[1:0];
                    const_d[i*DATA_WIDTH +: DATA_WIDTH] = cfg.cfg_wdata[DATA_WIDTH+7:8];
                end
                if (rd_accept) begin
                    if (is_data) begin
                        rdata_d[DATA_WIDTH-1:0] = reg_value[i*DATA_WIDTH +: DATA_WIDTH];
                    end else begin
                        rdata_d[1:0]            = mode_q[i*2 +: 2];
                        rdata_d[DATA_WIDTH+7:8] = const_q[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            mode_q        <= '0;
            const_q       <= '0;
            config_we_q   <= '0;
            config_data_q <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            const_q       <= const_d;
            config_we_q   <= config_we_d;
            config_data_q <= config_data_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    assign mode           = mode_q;
    assign const_         = const_q;
    assign config_we      = config_we_q;
    assign config_data    = config_data_q;
    assign clk_en         = {NUM_REGS{~stall}};
    assign cfg.cfg_rdata  = rdata_q;
    assign cfg.cfg_rvalid = rvalid_q;

endmodule

// File: tb/tb_reg_mode_cfg_ctrl.sv
// Bench for reg_mode_cfg_ctrl: a scoreboard of expected read responses and load pulses
// checked by a negedge monitor, plus direct checks of the held mode/const state.
module tb_reg_mode_cfg_ctrl;
    localparam int unsigned NR = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reg_mode_cfg_ctrl_if #(.ADDR_WIDTH(AW), .CFG_WIDTH(CW)) cfg_bus ();

    logic              stall;
    logic [NR*DW-1:0]  reg_value;
    logic [NR*2-1:0]   mode;
    logic [NR*DW-1:0]  const_;
    logic [NR-1:0]     clk_en;
    logic [NR-1:0]     config_we;
    logic [DW-1:0]     config_data;

    reg_mode_cfg_ctrl #(
        .NUM_REGS  (NR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CFG_WIDTH (CW)
    ) dut (
        .CLK        (clk),
        .ASYNCRESETN(rst_n),
        .cfg        (cfg_bus),
        .stall      (stall),
        .reg_value  (reg_value),
        .mode       (mode),
        .const_     (const_),
        .clk_en     (clk_en),
        .config_we  (config_we),
        .config_data(config_data)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [CW-1:0]    rd_q[$];
    logic [NR+DW-1:0] we_q[$];
    logic [1:0]       m_mode[NR];
    logic [DW-1:0]    m_const[NR];
    logic [DW-1:0]    m_cdata;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NR*2-1:0] exp_mode_vec();
        logic [NR*2-1:0] v;
        for (int i = 0; i < NR; i++) v[i*2 +: 2] = m_mode[i];
        return v;
    endfunction

    function automatic logic [NR*DW-1:0] exp_const_vec();
        logic [NR*DW-1:0] v;
        for (int i = 0; i < NR; i++) v[i*DW +: DW] = m_const[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_mode[i]  = '0;
            m_const[i] = '0;
        end
        m_cdata = '0;
    endtask

    // Called at posedge+1; presents one bus cycle, records expectations, returns at posedge+1.
    task automatic bus_cycle(input logic wr, input logic rd, input logic [AW-1:0] addr,
                             input logic [CW-1:0] wdata);
        int unsigned   slot    = int'(addr) >> 1;
        logic          mapped  = (int'(addr) < 2 * NR);
        logic          is_data = addr[0];
        logic [CW-1:0] exp_rd  = '0;
        logic [NR-1:0] oh      = '0;
        cfg_bus.cfg_write = wr;
        cfg_bus.cfg_read  = rd;
        cfg_bus.cfg_addr  = addr;
        cfg_bus.cfg_wdata = wdata;
        if (rd && !wr) begin
            if (mapped) begin
                if (is_data) exp_rd[DW-1:0] = reg_value[slot*DW +: DW];
                else begin
                    exp_rd[1:0]    = m_mode[slot];
                    exp_rd[DW+7:8] = m_const[slot];
                end
            end
            rd_q.push_back(exp_rd);
        end
        if (wr && mapped) begin
            if (is_data) begin
                oh[slot] = 1'b1;
                m_cdata  = wdata[DW-1:0];
                we_q.push_back({oh, wdata[DW-1:0]});
            end else begin
                m_mode[slot]  = wdata[1:0];
                m_const[slot] = wdata[DW+7:8];
            end
        end
        @(posedge clk);
        #1;
        cfg_bus.cfg_write = 1'b0;
        cfg_bus.cfg_read  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cfg_bus.cfg_rvalid) begin
                if (rd_q.size() == 0) check_eq("rvalid_unexpected", 64'(cfg_bus.cfg_rvalid), 64'd0);
                else check_eq("rdata", 64'(cfg_bus.cfg_rdata), 64'(rd_q.pop_front()));
            end else if (cfg_bus.cfg_rdata !== '0) begin
                check_eq("rdata_idle", 64'(cfg_bus.cfg_rdata), 64'd0);
            end
            if (config_we !== '0) begin
                if (we_q.size() == 0) check_eq("we_unexpected", 64'(config_we), 64'd0);
                else check_eq("we_pulse", 64'({config_we, config_data}), 64'(we_q.pop_front()));
            end
        end
    end

    initial begin
        cfg_bus.cfg_write = 1'b0;
        cfg_bus.cfg_read  = 1'b0;
        cfg_bus.cfg_addr  = '0;
        cfg_bus.cfg_wdata = '0;
        stall     = 1'b0;
        reg_value = '0;
        model_reset();

        // Reset held with strobes toggling: everything but clk_en stays 0.
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            cfg_bus.cfg_write = k[0];
            cfg_bus.cfg_read  = ~k[0];
            cfg_bus.cfg_addr  = 8'(k + 2);
            cfg_bus.cfg_wdata = $urandom;
            #1;
            check_eq("rst_outs", 64'({mode, const_, config_we, config_data,
                                       cfg_bus.cfg_rvalid, cfg_bus.cfg_rdata}), 64'd0);
        end
        check_eq("rst_clk_en", 64'(clk_en), 64'hF);
        cfg_bus.cfg_write = 1'b0;
        cfg_bus.cfg_read  = 1'b0;
        rst_n = 1'b1;
        idle(2);
        check_eq("post_rst_state", 64'({mode, const_, config_data}), 64'd0);

        // CTRL write and readback.
        bus_cycle(1'b1, 1'b0, 8'h04, 32'h0000_0A02);
        check_eq("ctrl_mode", 64'(mode), 64'(exp_mode_vec()));
        check_eq("ctrl_const", 64'(const_), 64'(exp_const_vec()));
        bus_cycle(1'b0, 1'b1, 8'h04, 32'h0);
        idle(1);

        // DATA writes: single pulse, then back-to-back pulses.
        bus_cycle(1'b1, 1'b0, 8'h03, 32'h7);
        idle(2);
        check_eq("cdata_hold", 64'(config_data), 64'(m_cdata));
        bus_cycle(1'b1, 1'b0, 8'h01, 32'h3);
        bus_cycle(1'b1, 1'b0, 8'h07, 32'h9);
        idle(2);

        // Readback of DATA sampled at accept, unmapped read/write.
        reg_value = 16'hC05A;
        bus_cycle(1'b0, 1'b1, 8'h03, 32'h0);
        reg_value = 16'hFFFF;
        idle(1);
        reg_value = 16'hC05A;
        bus_cycle(1'b0, 1'b1, 8'h07, 32'h0);
        bus_cycle(1'b0, 1'b1, 8'h20, 32'h0);
        bus_cycle(1'b1, 1'b0, 8'h20, 32'hFFFF_FFFF);
        idle(1);
        check_eq("unmapped_mode", 64'(mode), 64'(exp_mode_vec()));
        check_eq("unmapped_const", 64'(const_), 64'(exp_const_vec()));
        check_eq("unmapped_cdata", 64'(config_data), 64'(m_cdata));

        // Collision: write lands, read dropped; ignored wdata bits read back as 0.
        bus_cycle(1'b1, 1'b1, 8'h00, 32'hFFFF_F5FD);
        check_eq("coll_mode", 64'(mode), 64'(exp_mode_vec()));
        check_eq("coll_const", 64'(const_), 64'(exp_const_vec()));
        idle(2);
        bus_cycle(1'b0, 1'b1, 8'h00, 32'h0);
        idle(1);

        // Stall gates clk_en combinationally but not config loads.
        stall = 1'b1;
        #1;
        check_eq("stall_clk_en", 64'(clk_en), 64'h0);
        bus_cycle(1'b1, 1'b0, 8'h05, 32'hE);
        idle(1);
        stall = 1'b0;
        #1;
        check_eq("unstall_clk_en", 64'(clk_en), 64'hF);

        // Reset lands while a DATA write is pending: no pulse, state clears without a clock.
        @(posedge clk);
        #1;
        cfg_bus.cfg_write = 1'b1;
        cfg_bus.cfg_addr  = 8'h01;
        cfg_bus.cfg_wdata = 32'h6;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_eq("midrst_mode", 64'(mode), 64'(exp_mode_vec()));
        check_eq("midrst_const", 64'(const_), 64'(exp_const_vec()));
        @(posedge clk);
        #1;
        cfg_bus.cfg_write = 1'b0;
        check_eq("midrst_we", 64'(config_we), 64'd0);
        rst_n = 1'b1;
        idle(3);
        check_eq("midrst_cdata", 64'(config_data), 64'(m_cdata));

        check_eq("rd_q_drained", 64'(rd_q.size()), 64'd0);
        check_eq("we_q_drained", 64'(we_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_mode_cfg_ctrl.md
Name: reg_mode_cfg_ctrl

Overview:
Configuration front-end that sits directly upstream of a bank of mode-selectable data registers (each a 4-bit register with 2-bit mode and constant inputs).
- Decodes a simple addressed config bus.
- Holds each slot's mode and constant values.
- Generates the per-slot config write-enable pulse and config data that load a value straight into the register.
- Gates per-slot clock enables with a global stall.
- Returns register contents on readback with fixed one-cycle latency.

Parameters:
NUM_REGS, 4, number of downstream register slots (1..16)
DATA_WIDTH, 4, width of each slot's value/const/config_data
ADDR_WIDTH, 8, config address width
CFG_WIDTH, 32, config bus data width (must be >= DATA_WIDTH+8)

Ports:
CLK  input  1  clock, rising edge
ASYNCRESETN  input  1  asynchronous active-low reset
cfg_write  input  1  config write strobe, single-cycle accept
cfg_read  input  1  config read strobe, single-cycle accept
cfg_addr  input  ADDR_WIDTH  config address
cfg_wdata  input  CFG_WIDTH  config write data
cfg_rdata  output  CFG_WIDTH  read data, valid with cfg_rvalid
cfg_rvalid  output  1  read response strobe
stall  input  1  global stall
reg_value  input  NUM_REGS*DATA_WIDTH  current register contents per slot; slot i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
mode  output  NUM_REGS*2  per-slot mode field
const_  output  NUM_REGS*DATA_WIDTH  per-slot constant
clk_en  output  NUM_REGS  per-slot clock enable
config_we  output  NUM_REGS  one-hot config write pulse
config_data  output  DATA_WIDTH  shared config load data

Behaviour:
- Clocking and reset: single clock domain on CLK. ASYNCRESETN low asynchronously clears every flop, and all outputs read 0 while it is held low: mode, const_, config_we, config_data, cfg_rdata, cfg_rvalid. clk_en is combinational (~stall), so it is not held low by reset.
- A pending config_we pulse or read response is dropped if reset hits mid-operation. Operation resumes on the first CLK edge after release.
- Address map, slot i in 0..NUM_REGS-1:
  - addr 2i (CTRL): wdata[1:0] -> mode[i]; wdata[DATA_WIDTH+7:8] -> const_[i]. Other bits are ignored and read back as 0.
  - addr 2i+1 (DATA): a write issues the load into slot i; a read returns reg_value slot i, zero-extended.
  - Addresses >= 2*NUM_REGS are unmapped: writes have no effect; reads respond with rdata=0 and rvalid=1.
  - The mode field is stored opaquely; its encoding belongs to the consuming register stage.
- CTRL write: mode/const_ update on the accepting edge and are visible the following cycle.
- DATA write:
  - On the accepting edge, config_data <= wdata[DATA_WIDTH-1:0] and config_we <= one-hot(i).
  - config_we is high for exactly one cycle, the cycle after accept. The downstream register captures on the next edge.
  - config_data holds its value until the next DATA write.
  - Back-to-back DATA writes produce back-to-back pulses, each with its own data.
- Read:
  - cfg_read accepted at edge N -> cfg_rvalid=1 and cfg_rdata valid during cycle N+1.
  - cfg_rvalid is a 1-cycle pulse; cfg_rdata returns to 0 when rvalid is 0.
  - Reading DATA samples reg_value at the accept edge.
  - A read issued the cycle after a DATA write to the same slot returns the pre-load value. The value loaded by that write appears on a read accepted 2 cycles after the write.
- Simultaneous cfg_write and cfg_read: the write is performed, the read is dropped, and cfg_rvalid stays 0.
- clk_en[i] = ~stall, combinational, for all slots. Stall does not block config writes; config_we must still load while stalled.
- No internal backpressure: every strobe is accepted in the cycle it is presented.

Test Plan:
1. Reset: hold ASYNCRESETN=0 with stall=0 and strobes toggling -> all outputs 0 except clk_en=4'b1111. Deassert -> values stay 0 until the first write.
2. CTRL write: addr 0x04, wdata 0x0000_0A02 -> next cycle mode[slot2]=2'b10, const_[slot2]=4'hA, other slots unchanged. Read addr 0x04 -> rvalid one cycle later, rdata=0x0000_0A02.
3. DATA write: addr 0x03, wdata 0x7 -> config_we=4'b0010 for exactly one cycle, then 0; config_data=4'h7. Back-to-back writes to 0x01 (0x3) then 0x07 (0x9) -> pulses 4'b0001 then 4'b1000 on consecutive cycles with data 3 then 9.
4. Readback: reg_value slot1=4'h5, read addr 0x03 -> cycle+1: rvalid=1, rdata=0x5. Read addr 0x20 (unmapped) -> rdata=0, rvalid=1. Write to 0x20 -> no change to mode, const_, config_we or config_data.
5. Collision and stall: cfg_write and cfg_read together at addr 0x00 -> mode/const update, rvalid stays 0. stall=1 -> clk_en=0 in the same cycle, and a DATA write still pulses config_we.
6. Reset mid-op: assert ASYNCRESETN=0 between a DATA write accept and its pulse -> config_we never asserts, mode/const_ clear immediately without waiting for a clock edge.
